// File: rtl/sram_1w1r_pkg.sv
// -----------------------------------------------------------------------------
// sram_1w1r_pkg
// Shared definitions for the tiled 1W1R SRAM wrapper: derived-width helpers
// and the sweep/ready state enum.
// No ports.
// -----------------------------------------------------------------------------
package sram_1w1r_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  // Address width; a single-word memory still needs one address bit.
  function automatic int calc_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int calc_mw(input int data_w, input int mask_gran);
    return data_w / mask_gran;
  endfunction

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic int calc_cols(input int data_w, input int macro_w);
    return ceil_div(data_w, macro_w);
  endfunction

  function automatic int calc_banks(input int depth, input int macro_depth);
    return ceil_div(depth, macro_depth);
  endfunction

endpackage

// File: rtl/sram_1w1r_macro.sv
// -----------------------------------------------------------------------------
// sram_1w1r_macro
// One WORD_W x NUM_ROWS tile with a write port and a registered read port.
// Behavioural stand-in for the freepdk45_sram_1w1r hard macro, whose port
// list it mirrors one-for-one so the netlist swap is a rename.
// Ports:
//   clk0    in  write-port clock
//   csb0    in  write-port select, active low
//   wmask0  in  per-lane write enable, active low (lane = LANE_W bits)
//   addr0   in  write row
//   din0    in  write data
//   clk1    in  read-port clock
//   csb1    in  read-port select, active low
//   addr1   in  read row
//   dout1   out read data, updated on the clock after a selected read
// -----------------------------------------------------------------------------
module sram_1w1r_macro #(
  parameter  int WORD_W   = 64,
  parameter  int NUM_ROWS = 512,
  parameter  int LANE_W   = 8,
  localparam int ROW_W    = $clog2(NUM_ROWS),
  localparam int LANES    = WORD_W / LANE_W
) (
  input  logic              clk0,
  input  logic              csb0,
  input  logic [LANES-1:0]  wmask0,
  input  logic [ROW_W-1:0]  addr0,
  input  logic [WORD_W-1:0] din0,
  input  logic              clk1,
  input  logic              csb1,
  input  logic [ROW_W-1:0]  addr1,
  output logic [WORD_W-1:0] dout1
);

  logic [WORD_W-1:0] mem_q [NUM_ROWS];

  always_ff @(posedge clk0) begin
    if (!csb0) begin
      for (int l = 0; l < LANES; l++) begin
        if (!wmask0[l]) mem_q[addr0][l*LANE_W +: LANE_W] <= din0[l*LANE_W +: LANE_W];
      end
    end
  end

  // A read colliding with a write returns the pre-write row contents.
  always_ff @(posedge clk1) begin
    if (!csb1) dout1 <= mem_q[addr1];
  end

endmodule

// File: rtl/sram_1w1r_tiled.sv
// -----------------------------------------------------------------------------
// sram_1w1r_tiled
// DATA_W x DEPTH one-write/one-read memory built from a BANKS x COLS grid of
// sram_1w1r_macro tiles. After reset it zero-fills every word, then serves
// user reads (1-cycle latency, held output) and masked writes.
// Build option: define SRAM_1W1R_BYPASS_EN to forward written lanes into a
// read of the same address issued in the same cycle.
// Ports:
//   clock      in  sole clock
//   reset      in  synchronous, active high
//   W0_addr    in  write address
//   W0_data    in  write data
//   W0_en      in  write enable
//   W0_mask    in  per-lane write enable (MASK_GRAN bits per lane)
//   R0_addr    in  read address
//   R0_en      in  read enable
//   R0_data    out read data, changes only the cycle after an accepted read
//   init_done  out high once the zero sweep has completed
//
// state | meaning
// INIT  | zero sweep in progress, user requests ignored
// READY | sweep done, user reads/writes served until reset
// -----------------------------------------------------------------------------
module sram_1w1r_tiled
  import sram_1w1r_pkg::*;
#(
  parameter  int DATA_W      = 64,
  parameter  int DEPTH       = 512,
  parameter  int MASK_GRAN   = 8,
  parameter  int MACRO_W     = 64,
  parameter  int MACRO_DEPTH = 512,
  localparam int AW          = calc_aw(DEPTH),
  localparam int MW          = calc_mw(DATA_W, MASK_GRAN)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [AW-1:0]     W0_addr,
  input  logic [DATA_W-1:0] W0_data,
  input  logic              W0_en,
  input  logic [MW-1:0]     W0_mask,
  input  logic [AW-1:0]     R0_addr,
  input  logic              R0_en,
  output logic [DATA_W-1:0] R0_data,
  output logic              init_done
);

  localparam int COLS  = calc_cols(DATA_W, MACRO_W);
  localparam int BANKS = calc_banks(DEPTH, MACRO_DEPTH);
  localparam int RW    = $clog2(MACRO_DEPTH);
  localparam int LPM   = MACRO_W / MASK_GRAN;
  localparam int PW    = COLS * MACRO_W;
  localparam int PL    = COLS * LPM;
  localparam int XW    = AW + RW;
  localparam int BW    = calc_aw(BANKS);

  state_e            state_q;
  logic [AW-1:0]     init_cnt_q;
  logic              init_done_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (init_cnt_q == AW'(DEPTH - 1)) begin
            state_q     <= READY;
            init_done_q <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + 1'b1;
          end
        end
        READY:   init_done_q <= 1'b1;
        default: state_q <= INIT;
      endcase
    end
  end

  logic ready;
  assign ready = (state_q == READY);

  logic w_in_range, r_in_range;
  assign w_in_range = ({1'b0, W0_addr} < (AW+1)'(DEPTH));
  assign r_in_range = ({1'b0, R0_addr} < (AW+1)'(DEPTH));

  // The sweep owns the write port while INIT; the user owns it after.
  logic [AW-1:0] wr_addr;
  logic          wr_go;
  logic [PW-1:0] wr_data;
  logic [PL-1:0] wr_lanes;

  always_comb begin
    wr_addr  = init_cnt_q;
    wr_go    = 1'b1;
    wr_data  = '0;
    wr_lanes = '1;
    if (ready) begin
      wr_addr  = W0_addr;
      wr_go    = W0_en && w_in_range && (|W0_mask);
      wr_data  = PW'(W0_data);
      wr_lanes = PL'(W0_mask);
    end
  end

  logic          rd_go;
  logic [XW-1:0] wa_ext, ra_ext;
  logic [RW-1:0] wr_row, rd_row;
  assign rd_go  = ready && R0_en;
  assign wa_ext = XW'(wr_addr);
  assign ra_ext = XW'(R0_addr);
  assign wr_row = wa_ext[RW-1:0];
  assign rd_row = ra_ext[RW-1:0];

  logic [BANKS-1:0]    wr_csb, rd_csb;
  logic [BANKS*PW-1:0] bank_rdata;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    assign wr_csb[b] = !(wr_go && ((wa_ext >> RW) == XW'(b)));
    assign rd_csb[b] = !(rd_go && r_in_range && ((ra_ext >> RW) == XW'(b)));
    for (genvar c = 0; c < COLS; c++) begin : g_col
      sram_1w1r_macro #(
        .WORD_W   (MACRO_W),
        .NUM_ROWS (MACRO_DEPTH),
        .LANE_W   (MASK_GRAN)
      ) u_macro (
        .clk0   (clock),
        .csb0   (wr_csb[b]),
        .wmask0 (~wr_lanes[c*LPM +: LPM]),
        .addr0  (wr_row),
        .din0   (wr_data[c*MACRO_W +: MACRO_W]),
        .clk1   (clock),
        .csb1   (rd_csb[b]),
        .addr1  (rd_row),
        .dout1  (bank_rdata[b*PW + c*MACRO_W +: MACRO_W])
      );
    end
  end

  logic          rd_acc_q, rd_inr_q;
  logic [BW-1:0] rd_bank_q;
  logic [PW-1:0] sel_rdata;

  always_comb begin
    sel_rdata = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (rd_bank_q == BW'(b)) sel_rdata = bank_rdata[b*PW +: PW];
    end
  end

  logic [DATA_W-1:0] rd_word, merged, r0_data_d, r0_data_q;
  assign rd_word = sel_rdata[DATA_W-1:0];

`ifdef SRAM_1W1R_BYPASS_EN
  logic              collide;
  logic              byp_q;
  logic [DATA_W-1:0] byp_data_q;
  logic [MW-1:0]     byp_mask_q;

  assign collide = rd_go && W0_en && w_in_range && r_in_range && (W0_addr == R0_addr);

  always_ff @(posedge clock) begin
    if (reset) begin
      byp_q      <= 1'b0;
      byp_data_q <= '0;
      byp_mask_q <= '0;
    end else begin
      byp_q <= collide;
      if (collide) begin
        byp_data_q <= W0_data;
        byp_mask_q <= W0_mask;
      end
    end
  end

  always_comb begin
    merged = rd_word;
    for (int l = 0; l < MW; l++) begin
      if (byp_q && byp_mask_q[l]) merged[l*MASK_GRAN +: MASK_GRAN] = byp_data_q[l*MASK_GRAN +: MASK_GRAN];
    end
  end
`else
  assign merged = rd_word;
`endif

  assign r0_data_d = rd_inr_q ? merged : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_acc_q  <= 1'b0;
      rd_inr_q  <= 1'b0;
      rd_bank_q <= '0;
      r0_data_q <= '0;
    end else begin
      rd_acc_q <= rd_go;
      if (rd_go) begin
        rd_inr_q  <= r_in_range;
        rd_bank_q <= BW'(ra_ext >> RW);
      end
      // Hold the last result unless a read was accepted on the previous edge.
      if (rd_acc_q) r0_data_q <= r0_data_d;
    end
  end

  assign R0_data   = r0_data_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_sram_1w1r_tiled.sv
module tb_sram_1w1r_tiled;

  localparam int DATA_W      = 64;
  localparam int DEPTH       = 600;
  localparam int MASK_GRAN   = 8;
  localparam int MACRO_W     = 32;
  localparam int MACRO_DEPTH = 512;
  localparam int AW          = 10;
  localparam int MW          = 8;
  localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

`ifdef SRAM_1W1R_BYPASS_EN
  localparam logic [63:0] COLLIDE_CMP = ALL;
`else
  localparam logic [63:0] COLLIDE_CMP = 64'h0000_0000_FFFF_FFFF;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [AW-1:0]     W0_addr = '0;
  logic [DATA_W-1:0] W0_data = '0;
  logic              W0_en = 1'b0;
  logic [MW-1:0]     W0_mask = '0;
  logic [AW-1:0]     R0_addr = '0;
  logic              R0_en = 1'b0;
  logic [DATA_W-1:0] R0_data;
  logic              init_done;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_q[$];
  logic [63:0] cmask_q[$];
  string       name_q[$];

  logic rd_q1 = 1'b0;
  logic rd_q2 = 1'b0;

  always #5 clock = ~clock;

  sram_1w1r_tiled #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .MASK_GRAN   (MASK_GRAN),
    .MACRO_W     (MACRO_W),
    .MACRO_DEPTH (MACRO_DEPTH)
  ) u_dut (
    .clock     (clock),
    .reset     (reset),
    .W0_addr   (W0_addr),
    .W0_data   (W0_data),
    .W0_en     (W0_en),
    .W0_mask   (W0_mask),
    .R0_addr   (R0_addr),
    .R0_en     (R0_en),
    .R0_data   (R0_data),
    .init_done (init_done)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp, input logic [63:0] cm);
    n_checks++;
    if ((act & cm) !== (exp & cm)) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h (compared bits 0x%016h)", nm, act, exp, cm);
    end
  endtask

  // Read data is due on the second edge after the bench raised R0_en.
  always @(posedge clock) begin
    rd_q1 <= R0_en;
    rd_q2 <= rd_q1;
  end

  always @(negedge clock) begin
    logic [63:0] e;
    logic [63:0] m;
    string       s;
    if (rd_q2) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_read: got 0x%016h with no expected value queued", R0_data);
      end else begin
        e = exp_q.pop_front();
        m = cmask_q.pop_front();
        s = name_q.pop_front();
        check(s, R0_data, e, m);
      end
    end
  end

  task automatic cyc(input logic wen, input logic [AW-1:0] wa, input logic [63:0] wd, input logic [MW-1:0] wm,
                     input logic ren, input logic [AW-1:0] ra, input logic [63:0] exp, input logic [63:0] cm,
                     input string nm);
    W0_en   = wen;
    W0_addr = wa;
    W0_data = wd;
    W0_mask = wm;
    R0_en   = ren;
    R0_addr = ra;
    if (ren) begin
      exp_q.push_back(exp);
      cmask_q.push_back(cm);
      name_q.push_back(nm);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [63:0] d, input logic [MW-1:0] m);
    cyc(1'b1, a, d, m, 1'b0, '0, '0, '0, "");
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [63:0] exp, input string nm);
    cyc(1'b0, '0, '0, '0, 1'b1, a, exp, ALL, nm);
  endtask

  task automatic idle(input int n);
    W0_en = 1'b0;
    R0_en = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    int cnt;

    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_r0_data", R0_data, 64'h0, ALL);
    check("reset_init_done", 64'(init_done), 64'h0, ALL);

    // First sweep, interrupted at count 100.
    reset = 1'b0;
    repeat (100) @(posedge clock);
    #1;
    check("init_low_at_100", 64'(init_done), 64'h0, ALL);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("init_low_in_reset", 64'(init_done), 64'h0, ALL);

    // Second sweep: count edges until init_done; a user write mid-sweep must be lost.
    reset = 1'b0;
    cnt = 0;
    while (!init_done && cnt < DEPTH + 50) begin
      if (cnt == 300) begin
        W0_en   = 1'b1;
        W0_addr = AW'(7);
        W0_data = ALL;
        W0_mask = '1;
      end else begin
        W0_en = 1'b0;
      end
      @(posedge clock);
      #1;
      cnt++;
    end
    W0_en = 1'b0;
    check("init_sweep_cycles", 64'(cnt), 64'(DEPTH), ALL);

    rd(AW'(0),   64'h0, "zero_addr0");
    rd(AW'(255), 64'h0, "zero_addr255");
    rd(AW'(511), 64'h0, "zero_addr511");
    rd(AW'(599), 64'h0, "zero_addr599");
    rd(AW'(7),   64'h0, "init_write_lost");

    // Partial write across both macro columns.
    wr(AW'(20), 64'h1122_3344_5566_7788, 8'hFF);
    wr(AW'(20), 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    rd(AW'(20), 64'h1122_3344_AAAA_AAAA, "partial_write");
    wr(AW'(20), ALL, 8'h00);
    rd(AW'(20), 64'h1122_3344_AAAA_AAAA, "zero_mask_write");

    // Same-cycle write/read collision on a zeroed word.
    cyc(1'b1, AW'(30), ALL, 8'hF0, 1'b1, AW'(30), 64'hFFFF_FFFF_0000_0000, COLLIDE_CMP, "collision");
    rd(AW'(30), 64'hFFFF_FFFF_0000_0000, "collision_after");

    // Bank boundary and out-of-range handling.
    wr(AW'(511), 64'hDEAD, 8'hFF);
    wr(AW'(512), 64'hBEEF, 8'hFF);
    wr(AW'(88),  64'h88,   8'hFF);
    wr(AW'(600), 64'h1234, 8'hFF);
    rd(AW'(511), 64'hDEAD, "bank0_top");
    rd(AW'(512), 64'hBEEF, "bank1_bottom");
    rd(AW'(88),  64'h88,   "oor_write_dropped");
    rd(AW'(600), 64'h0,    "oor_read_600");
    rd(AW'(512), 64'hBEEF, "bank1_reread");
    rd(AW'(1000), 64'h0,   "oor_read_1000");

    // Back-to-back traffic: write then read on the next cycle.
    cyc(1'b1, AW'(40), 64'h4040_0000_0000_4040, 8'hFF, 1'b1, AW'(511), 64'hDEAD, ALL, "b2b_read511");
    cyc(1'b1, AW'(41), 64'h4141_4141_4141_4141, 8'hFF, 1'b1, AW'(40), 64'h4040_0000_0000_4040, ALL, "b2b_read40");
    cyc(1'b0, '0, '0, '0, 1'b1, AW'(41), 64'h4141_4141_4141_4141, ALL, "b2b_read41");

    // Output hold while the addressed word keeps changing underneath.
    wr(AW'(5), 64'h5A, 8'hFF);
    rd(AW'(5), 64'h5A, "hold_read");
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, AW'(5), 64'(256 + i), 8'hFF, 1'b0, '0, '0, '0, "");
      check("hold_r0_data", R0_data, 64'h5A, ALL);
    end
    rd(AW'(5), 64'h109, "after_hold");

    idle(4);
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0, ALL);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_1w1r_tiled.md
# sram_1w1r_tiled

Parametrised one-write/one-read SRAM wrapper that builds an arbitrary DATA_W × DEPTH memory from a grid of fixed-size FreePDK45 OpenRAM 1W1R macros. It is the common replacement for the per-memory `*_ext` shims in the SmallProBoom memory map and adds three things those shims lack:
- a post-reset zero-initialisation sweep;
- same-cycle write→read collision forwarding;
- an output hold register.

It sits between the Chisel-generated `*_ext` port list and the hard macros.

## Interface
Parameters:
- DATA_W, 64, logical word width in bits.
- DEPTH, 512, logical word count; need not be a power of two.
- MASK_GRAN, 8, bits per write-mask lane; DATA_W % MASK_GRAN == 0.
- MACRO_W, 64, macro word width; MACRO_W % MASK_GRAN == 0.
- MACRO_DEPTH, 512, macro row count; power of two.

Derived values:
- AW = $clog2(DEPTH).
- MW = DATA_W/MASK_GRAN.
- COLS = ceil(DATA_W/MACRO_W).
- BANKS = ceil(DEPTH/MACRO_DEPTH).

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  sole clock for every port and every macro.
- reset  in  1  synchronous, active-high.
- W0_addr  in  AW  write address.
- W0_data  in  DATA_W  write data.
- W0_en  in  1  write enable.
- W0_mask  in  MW  per-lane write enable.
- R0_addr  in  AW  read address.
- R0_en  in  1  read enable.
- R0_data  out  DATA_W  read data.
- init_done  out  1  high once the zero sweep has completed.

## Operation
- Tiling:
  - Column c holds bits [c*MACRO_W +: MACRO_W]; the top column is zero-padded.
  - Bank b = addr / MACRO_DEPTH; row = addr % MACRO_DEPTH.
  - Only the addressed bank receives csb low.
- FSM states: INIT and READY.
  - reset → INIT, init counter = 0.
  - INIT: each cycle write all-zero data with all mask lanes set to the counter address, then increment.
  - INIT: user W0_en/R0_en are ignored and no macro read is issued.
  - Counter reaching DEPTH-1 → READY in the next cycle.
  - READY is held until reset.
- Writes (READY):
  - W0_en=1 with W0_addr < DEPTH commits the lanes whose W0_mask bit is set.
  - W0_mask all-zero issues no macro write.
- Out-of-range accesses:
  - Write with W0_addr ≥ DEPTH is dropped.
  - Read with R0_addr ≥ DEPTH returns 0.
- Reads (READY):
  - R0_en=1 captures the bank select, collision info and range flag.
  - The selected bank's column outputs are muxed into the output register.
- Output hold: R0_data changes only in the cycle after an accepted read. Otherwise it holds its last value, whatever the macro output is doing.
- Collision: R0_en & W0_en with equal in-range addresses in the same cycle. Handling depends on SRAM_1W1R_BYPASS_EN (see Configuration).

## Timing
- Reset values: R0_data = 0, init_done = 0, FSM = INIT, init counter = 0.
- Init sweep: init_done rises exactly DEPTH cycles after the first cycle with reset low.
- Reset asserted mid-sweep restarts the counter at 0.
- Read latency: 1 cycle. Read accepted at edge N → R0_data valid after edge N+1.
- Write latency: a write at edge N is visible to a read issued at edge N+1.
- Back-to-back reads and writes are supported every cycle; there is no backpressure.
- User requests issued while init_done = 0 are lost; this is not an error.

## Configuration
Macro SRAM_1W1R_BYPASS_EN selects collision handling.
- Defined:
  - Write data, mask and a collision flag are registered.
  - On the output cycle, masked lanes take the forwarded W0_data; unmasked lanes take the macro output.
  - Result is new data for written lanes and old data for the others.
- Undefined:
  - No forwarding logic.
  - Written lanes of a colliding read are unspecified; unwritten lanes are old data.
  - The bench must not check written lanes.

## Structure
- Package sram_1w1r_pkg: derived-width functions (AW, MW, COLS, BANKS) and the FSM state enum {INIT, READY}.
- Sub-module sram_1w1r_macro:
  - one MACRO_W × MACRO_DEPTH tile;
  - behavioural model for simulation;
  - maps 1:1 to the freepdk45_sram_1w1r macro in synthesis;
  - active-low csb0/csb1 and wmask0.
- Top level holds the FSM, init counter, bank/column generate loops, read-select pipeline register, bypass register and output register.

## Test plan
- Reset release with DEPTH=512: init_done low for exactly 512 cycles then high; reads of addresses 0, 255 and 511 return 0.
- Reset pulsed at sweep count 100: counter restarts; init_done rises 512 cycles after the second reset release.
- Partial write with DATA_W=64, MASK_GRAN=8: write 0x1122334455667788 with mask 0xFF, then 0xAAAAAAAAAAAAAAAA with mask 0x0F, then read → 0x11223344AAAAAAAA.
- Collision with BYPASS_EN: old word 0x0, write 0xFFFF_FFFF_FFFF_FFFF with mask 0xF0 and read of the same address in one cycle → 0xFFFFFFFF00000000.
- Bank boundary with DEPTH=600, MACRO_DEPTH=512: write 0xDEAD at 511 and 0xBEEF at 512; reads return each value. Read at 600 → 0. Write at 600 → dropped, with no change at address 88.
- Hold: read address 5 (value 0x5A) then keep R0_en low for 10 cycles while writing address 5 → R0_data stays 0x5A.
